// File: rtl/led_chain_driver.sv
// led_chain_driver
// Serial driver for daisy-chained 12-bit constant-current LED driver boards.
// On a frame tick (when enabled) or on a trigger, it reads one sample per
// channel from a synchronous frame buffer. Channels go out from N-1 down to 0,
// each sample MSB first, on a registered serial clock. A latch pulse follows.
//
// Ports
//   i_clk, i_rst_n  system clock, asynchronous active-low reset
//   i_en            enables frame ticks (sampled only at frame start)
//   i_trigger       single-cycle start request, honoured only in IDLE
//   o_rd_addr       frame-buffer channel address
//   i_rd_data       sample, valid one cycle after o_rd_addr
//   o_busy          frame in progress (start through last latch cycle)
//   o_frame_done    one-cycle pulse after latch
//   o_overrun       one-cycle pulse when a tick arrives while not idle
//   o_clk/o_dai/o_lat  serial clock, serial data, latch
//
// state  | meaning
// IDLE   | waiting for tick&en or trigger
// FETCH0 | address presented, RAM read in flight
// FETCH1 | sample captured, MSB driven on o_dai
// SHIFT  | o_clk low phase then high phase per bit
// LATCH  | o_lat high for P_LAT_CYCLES
// DONE   | o_frame_done pulse; starts are accepted again next cycle
module led_chain_driver #(
    parameter int P_BOARDS       = 1,
    parameter int P_CH_PER_BOARD = 32,
    parameter int P_BPS          = 12,
    parameter int P_CLK_DIV      = 1,
    parameter int P_FRAME_PERIOD = 16666,
    parameter int P_LAT_CYCLES   = 1,
    localparam int N  = P_BOARDS * P_CH_PER_BOARD,
    localparam int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_trigger,
    output logic [AW-1:0]    o_rd_addr,
    input  logic [P_BPS-1:0] i_rd_data,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_overrun,
    output logic             o_clk,
    output logic             o_dai,
    output logic             o_lat
);

    localparam int DW = (P_CLK_DIV > 1) ? $clog2(P_CLK_DIV) : 1;
    localparam int LW = (P_LAT_CYCLES > 1) ? $clog2(P_LAT_CYCLES) : 1;
    localparam int BW = (P_BPS > 1) ? $clog2(P_BPS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH0,
        S_FETCH1,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [P_BPS-1:0] r_sh;
    logic [DW-1:0]    r_div;
    logic [LW-1:0]    r_lat;
    logic [BW-1:0]    r_bit;
    logic [P_BPS-1:0] w_sh_next;
    logic             w_tick;
    logic             w_start;

    generate
        if (P_FRAME_PERIOD > 0) begin : g_frame
            localparam int FW = (P_FRAME_PERIOD > 1) ? $clog2(P_FRAME_PERIOD) : 1;
            logic [FW-1:0] r_fcnt;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_fcnt <= '0;
                end else if (r_fcnt == FW'(P_FRAME_PERIOD - 1)) begin
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + FW'(1);
                end
            end

            assign w_tick = (r_fcnt == '0);
        end else begin : g_no_frame
            assign w_tick = 1'b0;
        end
    endgenerate

    assign w_start   = (w_tick & i_en) | i_trigger;
    assign w_sh_next = r_sh << 1;

    // o_clk doubles as the phase flag: low phase first, then high phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_sh         <= '0;
            r_div        <= '0;
            r_lat        <= '0;
            r_bit        <= '0;
            o_rd_addr    <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_overrun    <= 1'b0;
            o_clk        <= 1'b0;
            o_dai        <= 1'b0;
            o_lat        <= 1'b0;
        end else begin
            o_overrun    <= w_tick && (r_state != S_IDLE);
            o_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        o_rd_addr <= AW'(N - 1);
                        o_busy    <= 1'b1;
                        r_state   <= S_FETCH0;
                    end
                end
                S_FETCH0: begin
                    r_state <= S_FETCH1;
                end
                S_FETCH1: begin
                    r_sh    <= i_rd_data;
                    o_dai   <= i_rd_data[P_BPS-1];
                    r_bit   <= '0;
                    r_div   <= DW'(P_CLK_DIV - 1);
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_div != '0) begin
                        r_div <= r_div - DW'(1);
                    end else if (!o_clk) begin
                        o_clk <= 1'b1;
                        r_div <= DW'(P_CLK_DIV - 1);
                    end else begin
                        o_clk <= 1'b0;
                        r_div <= DW'(P_CLK_DIV - 1);
                        r_sh  <= w_sh_next;
                        if (r_bit != BW'(P_BPS - 1)) begin
                            r_bit <= r_bit + BW'(1);
                            o_dai <= w_sh_next[P_BPS-1];
                        end else if (o_rd_addr != '0) begin
                            // o_dai holds its value through the fetch; o_clk is low there.
                            o_rd_addr <= o_rd_addr - AW'(1);
                            r_state   <= S_FETCH0;
                        end else begin
                            o_dai   <= 1'b0;
                            o_lat   <= 1'b1;
                            r_lat   <= LW'(P_LAT_CYCLES - 1);
                            r_state <= S_LATCH;
                        end
                    end
                end
                S_LATCH: begin
                    if (r_lat != '0) begin
                        r_lat <= r_lat - LW'(1);
                    end else begin
                        o_lat        <= 1'b0;
                        o_busy       <= 1'b0;
                        o_frame_done <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
